spi_master_shifter: RTL and testbench

- Word-level SPI master (mode 0: CPOL=0, CPHA=0) that shifts a parallel TX word out on MOSI and captures MISO into an RX word.
- Sits directly upstream of the pins and downstream of the host/register logic. Owns chip-select framing and bit counting.
- Generates a registered, divided SCLK from clk_i. It does not gate clk_i, which keeps timing closure clean.

---
 rtl/spi_master_shifter.sv | 186 ++++++++++++++++++
 tb/tb_spi_master_shifter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_shifter.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_shifter
// Description : Word-level SPI mode-0 master. Frames one DATA_W word under
//               cs_n_o, shifts tx_data_i out MSB first on mosi_o and captures
//               miso_i into rx_data_o. SCLK is a registered divide of clk_i.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_shifter #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic              cs_n_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNT_W-1:0] C_BITS     = CNT_W'(DATA_W);
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [DIV_W-1:0] C_DIV_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_TRAIL = 2'd3
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [DATA_W-1:0]   r_tx_shift;
    logic [DATA_W-1:0]   r_rx_shift;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_rx_valid;
    logic                r_sclk;
    logic                r_mosi;
    logic                r_cs_n;

    state_t              w_state_nxt;
    logic [DIV_W-1:0]    w_div_nxt;
    logic [CNT_W-1:0]    w_bit_nxt;
    logic [DATA_W-1:0]   w_tx_nxt;
    logic [DATA_W-1:0]   w_rx_nxt;
    logic [DATA_W-1:0]   w_rx_data_nxt;
    logic                w_rx_valid_nxt;
    logic                w_sclk_nxt;
    logic                w_mosi_nxt;
    logic                w_cs_n_nxt;
    logic                w_div_last;

    // The half-period counter is shared by LEAD, SHIFT and TRAIL; each phase
    // lasts CLK_DIV cycles, so a single wrap flag drives every transition.
    assign w_div_last = (r_div_cnt == C_DIV_LAST);

    // Next-state and next-datapath decode; every SCLK edge is decided here so
    // the pins only ever change on a clk_i edge.
    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div_cnt;
        w_bit_nxt      = r_bit_cnt;
        w_tx_nxt       = r_tx_shift;
        w_rx_nxt       = r_rx_shift;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_sclk_nxt     = r_sclk;
        w_mosi_nxt     = r_mosi;
        w_cs_n_nxt     = r_cs_n;

        case (r_state)
            S_IDLE: begin
                if (tx_valid_i) begin
                    w_tx_nxt    = tx_data_i;
                    w_rx_nxt    = '0;
                    w_mosi_nxt  = tx_data_i[DATA_W-1];
                    w_cs_n_nxt  = 1'b0;
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_LEAD;
                end
            end

            S_LEAD: begin
                if (w_div_last) begin
                    // End of MOSI setup: this edge is the first SCLK rise.
                    w_div_nxt   = '0;
                    w_sclk_nxt  = 1'b1;
                    w_rx_nxt    = {r_rx_shift[DATA_W-2:0], miso_i};
                    w_bit_nxt   = r_bit_cnt + C_CNT_ONE;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_div_nxt = r_div_cnt + C_DIV_ONE;
                end
            end

            S_SHIFT: begin
                if (w_div_last) begin
                    w_div_nxt = '0;
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                        w_rx_nxt   = {r_rx_shift[DATA_W-2:0], miso_i};
                        w_bit_nxt  = r_bit_cnt + C_CNT_ONE;
                    end else begin
                        w_sclk_nxt = 1'b0;
                        if (r_bit_cnt == C_BITS) begin
                            // Final fall: publish the word, hold MOSI.
                            w_rx_data_nxt  = r_rx_shift;
                            w_rx_valid_nxt = 1'b1;
                            w_state_nxt    = S_TRAIL;
                        end else begin
                            w_tx_nxt   = r_tx_shift << 1;
                            w_mosi_nxt = r_tx_shift[DATA_W-2];
                        end
                    end
                end else begin
                    w_div_nxt = r_div_cnt + C_DIV_ONE;
                end
            end

            S_TRAIL: begin
                if (w_div_last) begin
                    w_div_nxt   = '0;
                    w_cs_n_nxt  = 1'b1;
                    w_mosi_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_div_nxt = r_div_cnt + C_DIV_ONE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any frame in flight at once.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_div_cnt  <= w_div_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_tx_shift <= w_tx_nxt;
            r_rx_shift <= w_rx_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_sclk     <= w_sclk_nxt;
            r_mosi     <= w_mosi_nxt;
            r_cs_n     <= w_cs_n_nxt;
        end
    end

    assign tx_ready_o = (r_state == S_IDLE);
    assign busy_o     = (r_state != S_IDLE);
    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;
    assign sclk_o     = r_sclk;
    assign mosi_o     = r_mosi;
    assign cs_n_o     = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_shifter
// Description : Self-checking bench for spi_master_shifter. Two instances
//               (CLK_DIV=2 and CLK_DIV=1) are checked cycle by cycle against
//               a timing model derived from the frame arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_shifter;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          sel;
    logic          tx_valid;
    logic [W-1:0]  tx_data;
    int            miso_mode;
    logic          miso_drv;

    logic          tx_ready_a, rx_valid_a, busy_a, sclk_a, mosi_a, cs_n_a, miso_a;
    logic          tx_ready_b, rx_valid_b, busy_b, sclk_b, mosi_b, cs_n_b, miso_b;
    logic [W-1:0]  rx_data_a, rx_data_b;
    logic          tx_valid_a, tx_valid_b;

    logic          tx_ready, rx_valid, busy, sclk, mosi, cs_n;
    logic [W-1:0]  rx_data;

    int            n_total = 0;
    int            n_bad   = 0;
    logic [W-1:0]  last_rx [0:1];

    assign tx_valid_a = tx_valid & ~sel;
    assign tx_valid_b = tx_valid & sel;
    assign miso_a     = (miso_mode == 0) ? mosi_a : miso_drv;
    assign miso_b     = (miso_mode == 0) ? mosi_b : miso_drv;

    assign tx_ready = sel ? tx_ready_b : tx_ready_a;
    assign rx_valid = sel ? rx_valid_b : rx_valid_a;
    assign busy     = sel ? busy_b     : busy_a;
    assign sclk     = sel ? sclk_b     : sclk_a;
    assign mosi     = sel ? mosi_b     : mosi_a;
    assign cs_n     = sel ? cs_n_b     : cs_n_a;
    assign rx_data  = sel ? rx_data_b  : rx_data_a;

    spi_master_shifter #(.DATA_W(W), .CLK_DIV(2)) u_dut_a (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid_a),
        .tx_ready_o (tx_ready_a),
        .rx_data_o  (rx_data_a),
        .rx_valid_o (rx_valid_a),
        .busy_o     (busy_a),
        .sclk_o     (sclk_a),
        .mosi_o     (mosi_a),
        .miso_i     (miso_a),
        .cs_n_o     (cs_n_a)
    );

    spi_master_shifter #(.DATA_W(W), .CLK_DIV(1)) u_dut_b (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid_b),
        .tx_ready_o (tx_ready_b),
        .rx_data_o  (rx_data_b),
        .rx_valid_o (rx_valid_b),
        .busy_o     (busy_b),
        .sclk_o     (sclk_b),
        .mosi_o     (mosi_b),
        .miso_i     (miso_b),
        .cs_n_o     (cs_n_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (dut%0d): got %0h expected %0h", tag, sel, got, exp);
        end
    endtask

    // miso modes: 0 loopback, 1 random per cycle, 2 tied high, 3 tied low
    task automatic set_miso();
        case (miso_mode)
            1:       miso_drv = 1'($urandom_range(0, 1));
            2:       miso_drv = 1'b1;
            default: miso_drv = 1'b0;
        endcase
    endtask

    task automatic check_reset_both();
        logic s_save;
        s_save = sel;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("rst cs_n",     32'(cs_n),     32'd1);
            chk("rst sclk",     32'(sclk),     32'd0);
            chk("rst mosi",     32'(mosi),     32'd0);
            chk("rst ready",    32'(tx_ready), 32'd1);
            chk("rst rx_valid", 32'(rx_valid), 32'd0);
            chk("rst busy",     32'(busy),     32'd0);
            chk("rst rx_data",  32'(rx_data),  32'd0);
        end
        sel = s_save;
        last_rx[0] = '0;
        last_rx[1] = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle cs_n",     32'(cs_n),     32'd1);
            chk("idle sclk",     32'(sclk),     32'd0);
            chk("idle busy",     32'(busy),     32'd0);
            chk("idle ready",    32'(tx_ready), 32'd1);
            chk("idle rx_valid", 32'(rx_valid), 32'd0);
            chk("idle rx_data",  32'(rx_data),  32'(last_rx[sel]));
            set_miso();
        end
    endtask

    // One full frame starting at a negedge with the selected DUT idle.
    // Cycle t counts from the handshake cycle T0.
    task automatic run_frame(input logic [W-1:0] tx, input int mode,
                             input bit chain, input logic [W-1:0] nxt, input bit poke);
        int d, tend, tr, k, j;
        logic exp_sclk;
        logic [W-1:0] exp_rx, prev_rx;
        logic hist [0:63];
        d       = sel ? 1 : 2;
        tend    = (2*W + 1) * d + 1;
        tr      = 1 + 2*W*d;
        prev_rx = last_rx[sel];
        exp_rx  = tx;
        chk("ready at T0", 32'(tx_ready), 32'd1);
        miso_mode = mode;
        tx_valid  = 1'b1;
        tx_data   = tx;
        set_miso();
        hist[0] = miso_drv;
        for (int t = 1; t <= tend; t++) begin
            @(negedge clk);
            if (t == 1) begin
                if (chain) tx_data = nxt;
                else       tx_valid = 1'b0;
            end
            if (poke && t == 2*d + 3) begin
                tx_valid = 1'b1;
                tx_data  = 8'h77;
            end
            if (poke && t == 2*d + 4) tx_valid = 1'b0;

            k = t - 1 - d;
            exp_sclk = (k >= 0) && (k < 2*W*d) && (((k / d) % 2) == 0);
            j = (t - 1) / (2*d);
            if (j > W - 1) j = W - 1;
            if (t == tr && mode != 0) begin
                for (int i = 0; i < W; i++) exp_rx[W-1-i] = hist[d + 2*i*d];
            end

            chk($sformatf("cs_n t=%0d", t),     32'(cs_n),     32'(t == tend));
            chk($sformatf("sclk t=%0d", t),     32'(sclk),     32'(exp_sclk));
            chk($sformatf("busy t=%0d", t),     32'(busy),     32'(t != tend));
            chk($sformatf("ready t=%0d", t),    32'(tx_ready), 32'(t == tend));
            chk($sformatf("rx_valid t=%0d", t), 32'(rx_valid), 32'(t == tr));
            chk($sformatf("mosi t=%0d", t),     32'(mosi),     (t == tend) ? 32'd0 : 32'(tx[W-1-j]));
            chk($sformatf("rx_data t=%0d", t),  32'(rx_data),  (t >= tr) ? 32'(exp_rx) : 32'(prev_rx));

            set_miso();
            hist[t] = miso_drv;
        end
        last_rx[sel] = exp_rx;
    endtask

    initial begin
        logic [W-1:0] rtx;
        rst_n     = 1'b0;
        sel       = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        miso_mode = 3;
        miso_drv  = 1'b0;
        last_rx[0] = '0;
        last_rx[1] = '0;

        repeat (2) @(negedge clk);
        check_reset_both();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Loopback 0xA5, then MISO high with 0x3C.
        run_frame(8'hA5, 0, 1'b0, 8'h00, 1'b0);
        idle(2);
        run_frame(8'h3C, 2, 1'b0, 8'h00, 1'b0);
        idle(1);

        // Back-to-back with tx_valid held: 0x01 then 0x80, MISO low.
        run_frame(8'h01, 3, 1'b1, 8'h80, 1'b0);
        run_frame(8'h80, 3, 1'b0, 8'h00, 1'b0);
        idle(2);

        // Offer 0x77 mid-shift; it must be ignored.
        run_frame(8'hC3, 1, 1'b0, 8'h00, 1'b1);
        idle(4);

        // Reset in the middle of a frame.
        miso_mode = 0;
        tx_valid  = 1'b1;
        tx_data   = 8'h96;
        @(negedge clk);
        tx_valid  = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre-reset cs_n", 32'(cs_n), 32'd0);
        rst_n = 1'b0;
        check_reset_both();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("in-reset rx_valid", 32'(rx_valid), 32'd0);
        end
        rst_n = 1'b1;
        idle(1);
        run_frame(8'h5A, 0, 1'b0, 8'h00, 1'b0);
        idle(1);

        // CLK_DIV=1 instance, loopback 0xFF.
        sel = 1'b1;
        idle(1);
        run_frame(8'hFF, 0, 1'b0, 8'h00, 1'b0);

        // Randomised frames across both instances and all MISO modes.
        for (int f = 0; f < 12; f++) begin
            sel = 1'($urandom_range(0, 1));
            idle($urandom_range(0, 2));
            rtx = W'($urandom);
            run_frame(rtx, $urandom_range(0, 3), 1'b0, 8'h00, 1'b0);
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
